// File: rtl/spi_pkg.sv
// Shared SPI definitions: FSM state encoding and mode-0 bus constants.
package spi_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2
    } spi_state_e;

    // Mode 0: serial clock idles low; chip select idles high
    localparam logic CPOL    = 1'b0;
    localparam logic CS_IDLE = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with rise/fall pulses on the synchronized value.
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din_i,
    output logic sync_o,
    output logic rise_c,
    output logic fall_c
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_o = sync_q[STAGES-1];
    assign rise_c = sync_q[STAGES-1] & ~prev_q;
    assign fall_c = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversampled CLK/D/cs_n, full-duplex byte shifting with a one-deep tx holding register.
module spi_slave
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        IDLE_Q      = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs_n,
    input  logic              CLK,
    input  logic              D,
    output logic              Q,
    output logic              q_oe,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              tx_underrun,
    output logic              abort
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    logic sclk_rise, sclk_fall, sclk_sync_unused;
    logic cs_sync, cs_rise, cs_fall;
    logic d_sync, d_rise_unused, d_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CPOL)) u_sclk_sync (
        .clk(clk), .reset_n(reset_n), .din_i(CLK),
        .sync_o(sclk_sync_unused), .rise_c(sclk_rise), .fall_c(sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(CS_IDLE)) u_cs_sync (
        .clk(clk), .reset_n(reset_n), .din_i(cs_n),
        .sync_o(cs_sync), .rise_c(cs_rise), .fall_c(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_d_sync (
        .clk(clk), .reset_n(reset_n), .din_i(D),
        .sync_o(d_sync), .rise_c(d_rise_unused), .fall_c(d_fall_unused)
    );

    spi_state_e        state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] hold_q, hold_d;
    logic              hold_empty_q, hold_empty_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              underrun_q, underrun_d;
    logic              abort_q, abort_d;
    logic              q_q, q_d;
    logic              q_oe_q, q_oe_d;
    logic              reload_pend_q, reload_pend_d;
    logic              urun_pend_q, urun_pend_d;
    logic              reload;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (cs_fall) state_d = S_LOAD;
            S_LOAD:  state_d = cs_sync ? S_IDLE : S_SHIFT;
            S_SHIFT: if (cs_rise) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state; an empty-holding underrun at a frame boundary is reported
    // only when the next byte actually starts, so a clean cs_n rise does not flag it.
    always_comb begin
        bit_cnt_d     = bit_cnt_q;
        rx_shift_d    = rx_shift_q;
        tx_shift_d    = tx_shift_q;
        hold_d        = hold_q;
        hold_empty_d  = hold_empty_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        underrun_d    = 1'b0;
        abort_d       = 1'b0;
        reload_pend_d = reload_pend_q;
        urun_pend_d   = urun_pend_q;
        reload        = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                bit_cnt_d     = '0;
                rx_shift_d    = '0;
                reload_pend_d = 1'b0;
                urun_pend_d   = 1'b0;
            end
            S_LOAD: reload = ~cs_sync;
            S_SHIFT: begin
                if (cs_rise) begin
                    abort_d       = (bit_cnt_q != '0);
                    bit_cnt_d     = '0;
                    rx_shift_d    = '0;
                    reload_pend_d = 1'b0;
                    urun_pend_d   = 1'b0;
                end else if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], d_sync};
                    if (urun_pend_q) begin
                        underrun_d  = 1'b1;
                        urun_pend_d = 1'b0;
                    end
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d     = '0;
                        rx_data_d     = {rx_shift_q[DATA_W-2:0], d_sync};
                        rx_valid_d    = 1'b1;
                        reload_pend_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall) begin
                    if (reload_pend_q) begin
                        reload_pend_d = 1'b0;
                        if (!hold_empty_q) begin
                            reload = 1'b1;
                        end else begin
                            tx_shift_d  = '0;
                            urun_pend_d = 1'b1;
                        end
                    end else begin
                        tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                    end
                end
            end
            default: ;
        endcase

        if (reload) begin
            if (hold_empty_q) begin
                tx_shift_d = '0;
                underrun_d = 1'b1;
            end else begin
                tx_shift_d   = hold_q;
                hold_empty_d = 1'b1;
            end
        end

        // Write accepted only into an empty holding register, after the reload decision
        if (tx_valid && hold_empty_q) begin
            hold_d       = tx_data;
            hold_empty_d = 1'b0;
        end

        q_d    = (state_d == S_IDLE) ? IDLE_Q : tx_shift_d[DATA_W-1];
        q_oe_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt_q     <= '0;
            rx_shift_q    <= '0;
            tx_shift_q    <= '0;
            hold_q        <= '0;
            hold_empty_q  <= 1'b1;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            underrun_q    <= 1'b0;
            abort_q       <= 1'b0;
            q_q           <= IDLE_Q;
            q_oe_q        <= 1'b0;
            reload_pend_q <= 1'b0;
            urun_pend_q   <= 1'b0;
        end else begin
            bit_cnt_q     <= bit_cnt_d;
            rx_shift_q    <= rx_shift_d;
            tx_shift_q    <= tx_shift_d;
            hold_q        <= hold_d;
            hold_empty_q  <= hold_empty_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            underrun_q    <= underrun_d;
            abort_q       <= abort_d;
            q_q           <= q_d;
            q_oe_q        <= q_oe_d;
            reload_pend_q <= reload_pend_d;
            urun_pend_q   <= urun_pend_d;
        end
    end

    assign Q           = q_q;
    assign q_oe        = q_oe_q;
    assign tx_ready    = hold_empty_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign tx_underrun = underrun_q;
    assign abort       = abort_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: a bit-banged mode-0 master with random timing and a byte-level slave model.
module tb_spi_slave;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cs_n = 1'b1;
    logic       CLK = 1'b0;
    logic       D = 1'b0;
    logic       Q, q_oe, tx_ready, rx_valid, tx_underrun, abort;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic [7:0] rx_data;

    int checks = 0;
    int errors = 0;
    int rxv_cnt = 0, urun_cnt = 0, abort_cnt = 0;

    // Byte-level model of the holding register and the expected underrun total
    logic       m_full = 1'b0;
    logic [7:0] m_hold = 8'h00;
    int         m_urun = 0;
    logic [7:0] m_last_rx = 8'h00;

    spi_slave #(.DATA_W(8), .SYNC_STAGES(2), .IDLE_Q(1'b0)) dut (
        .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .CLK(CLK), .D(D), .Q(Q), .q_oe(q_oe),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun), .abort(abort)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid === 1'b1)    rxv_cnt++;
        if (tx_underrun === 1'b1) urun_cnt++;
        if (abort === 1'b1)       abort_cnt++;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    task automatic load_tx(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        if (!m_full) begin
            m_full = 1'b1;
            m_hold = b;
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    // Byte the slave must present for the next frame, per the holding-register rule
    task automatic m_reload(output logic [7:0] exp_b);
        if (m_full) begin
            exp_b  = m_hold;
            m_full = 1'b0;
        end else begin
            exp_b = 8'h00;
            m_urun++;
        end
    endtask

    task automatic cs_low(output logic [7:0] exp_b);
        cs_n = 1'b0;
        m_reload(exp_b);
        repeat (10) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (6) @(negedge clk);
        cs_n = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] mosi, input int nbits, output logic [7:0] miso);
        int lo, hi;
        miso = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            lo = $urandom_range(10, 6);
            hi = $urandom_range(10, 6);
            D = mosi[3'(7 - i)];
            repeat (lo) @(negedge clk);
            miso = {miso[6:0], Q};
            CLK = 1'b1;
            repeat (hi) @(negedge clk);
            CLK = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (Q !== 1'b0)           begin errors++; $display("FAIL reset_Q got=%b exp=0", Q); end
        checks++; if (q_oe !== 1'b0)        begin errors++; $display("FAIL reset_q_oe got=%b exp=0", q_oe); end
        checks++; if (tx_ready !== 1'b1)    begin errors++; $display("FAIL reset_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (rx_data !== 8'h00)    begin errors++; $display("FAIL reset_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0)    begin errors++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (tx_underrun !== 1'b0) begin errors++; $display("FAIL reset_underrun got=%b exp=0", tx_underrun); end
        checks++; if (abort !== 1'b0)       begin errors++; $display("FAIL reset_abort got=%b exp=0", abort); end
    endtask

    task automatic test_basic(input logic [7:0] txb, input logic [7:0] mosi, input bit do_load);
        logic [7:0] exp_b, miso;
        int rx0, ab0;
        rx0 = rxv_cnt;
        ab0 = abort_cnt;
        if (do_load) load_tx(txb);
        cs_low(exp_b);
        checks++; if (q_oe !== 1'b1) begin errors++; $display("FAIL basic_q_oe got=%b exp=1", q_oe); end
        send_bits(mosi, 8, miso);
        cs_high();
        m_last_rx = mosi;
        checks++; if (miso !== exp_b)        begin errors++; $display("FAIL basic_miso got=%h exp=%h", miso, exp_b); end
        checks++; if (rx_data !== mosi)      begin errors++; $display("FAIL basic_rx_data got=%h exp=%h", rx_data, mosi); end
        checks++; if (rxv_cnt - rx0 !== 1)   begin errors++; $display("FAIL basic_rx_valid_cnt got=%0d exp=1", rxv_cnt - rx0); end
        checks++; if (urun_cnt !== m_urun)   begin errors++; $display("FAIL basic_underrun_cnt got=%0d exp=%0d", urun_cnt, m_urun); end
        checks++; if (abort_cnt - ab0 !== 0) begin errors++; $display("FAIL basic_abort_cnt got=%0d exp=0", abort_cnt - ab0); end
        checks++; if (q_oe !== 1'b0 || Q !== 1'b0) begin errors++; $display("FAIL basic_idle_pins got q_oe=%b Q=%b exp 0 0", q_oe, Q); end
    endtask

    task automatic test_back_to_back(input logic [7:0] t0, input logic [7:0] t1,
                                     input logic [7:0] r0, input logic [7:0] r1);
        logic [7:0] e0, e1, m0, m1;
        int rx0;
        rx0 = rxv_cnt;
        load_tx(t0);
        cs_low(e0);
        load_tx(t1);
        send_bits(r0, 8, m0);
        repeat (4) @(negedge clk);
        checks++; if (rx_data !== r0) begin errors++; $display("FAIL b2b_rx_first got=%h exp=%h", rx_data, r0); end
        m_reload(e1);
        send_bits(r1, 8, m1);
        cs_high();
        m_last_rx = r1;
        checks++; if (m0 !== e0)            begin errors++; $display("FAIL b2b_miso_first got=%h exp=%h", m0, e0); end
        checks++; if (m1 !== e1)            begin errors++; $display("FAIL b2b_miso_second got=%h exp=%h", m1, e1); end
        checks++; if (rx_data !== r1)       begin errors++; $display("FAIL b2b_rx_second got=%h exp=%h", rx_data, r1); end
        checks++; if (rxv_cnt - rx0 !== 2)  begin errors++; $display("FAIL b2b_rx_valid_cnt got=%0d exp=2", rxv_cnt - rx0); end
        checks++; if (urun_cnt !== m_urun)  begin errors++; $display("FAIL b2b_underrun_cnt got=%0d exp=%0d", urun_cnt, m_urun); end
    endtask

    task automatic test_abort(input logic [7:0] partial, input logic [7:0] held, input logic [7:0] full);
        logic [7:0] e, m;
        int rx0, ab0;
        rx0 = rxv_cnt;
        ab0 = abort_cnt;
        cs_low(e);
        load_tx(held);
        send_bits(partial, 5, m);
        cs_high();
        checks++; if (abort_cnt - ab0 !== 1)  begin errors++; $display("FAIL abort_cnt got=%0d exp=1", abort_cnt - ab0); end
        checks++; if (rxv_cnt - rx0 !== 0)    begin errors++; $display("FAIL abort_rx_valid_cnt got=%0d exp=0", rxv_cnt - rx0); end
        checks++; if (rx_data !== m_last_rx)  begin errors++; $display("FAIL abort_rx_kept got=%h exp=%h", rx_data, m_last_rx); end
        checks++; if (tx_ready !== !m_full)   begin errors++; $display("FAIL abort_hold_kept got=%b exp=%b", tx_ready, !m_full); end
        cs_low(e);
        send_bits(full, 8, m);
        cs_high();
        m_last_rx = full;
        checks++; if (m !== e)               begin errors++; $display("FAIL abort_next_miso got=%h exp=%h", m, e); end
        checks++; if (rx_data !== full)      begin errors++; $display("FAIL abort_next_rx got=%h exp=%h", rx_data, full); end
        checks++; if (abort_cnt - ab0 !== 1) begin errors++; $display("FAIL abort_next_no_abort got=%0d exp=1", abort_cnt - ab0); end
        checks++; if (urun_cnt !== m_urun)   begin errors++; $display("FAIL abort_underrun_cnt got=%0d exp=%0d", urun_cnt, m_urun); end
    endtask

    task automatic test_no_overwrite(input logic [7:0] a, input logic [7:0] b, input logic [7:0] mosi);
        logic [7:0] e, m;
        load_tx(a);
        load_tx(b);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL nover_tx_ready got=%b exp=0", tx_ready); end
        cs_low(e);
        send_bits(mosi, 8, m);
        cs_high();
        m_last_rx = mosi;
        checks++; if (m !== e)          begin errors++; $display("FAIL nover_miso got=%h exp=%h", m, e); end
        checks++; if (rx_data !== mosi) begin errors++; $display("FAIL nover_rx got=%h exp=%h", rx_data, mosi); end
    endtask

    task automatic test_reset_midframe(input logic [7:0] pre, input logic [7:0] txb, input logic [7:0] mosi);
        logic [7:0] e, m;
        load_tx(pre);
        cs_low(e);
        send_bits(8'hFF, 3, m);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (Q !== 1'b0 || q_oe !== 1'b0) begin errors++; $display("FAIL rstmid_pins got Q=%b q_oe=%b exp 0 0", Q, q_oe); end
        checks++; if (tx_ready !== 1'b1)  begin errors++; $display("FAIL rstmid_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (rx_data !== 8'h00)  begin errors++; $display("FAIL rstmid_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0 || tx_underrun !== 1'b0 || abort !== 1'b0)
            begin errors++; $display("FAIL rstmid_pulses got rv=%b ur=%b ab=%b exp 0 0 0", rx_valid, tx_underrun, abort); end
        CLK = 1'b0;
        cs_n = 1'b1;
        m_full = 1'b0;
        m_last_rx = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        load_tx(txb);
        cs_low(e);
        send_bits(mosi, 8, m);
        cs_high();
        m_last_rx = mosi;
        checks++; if (m !== e)          begin errors++; $display("FAIL rstmid_next_miso got=%h exp=%h", m, e); end
        checks++; if (rx_data !== mosi) begin errors++; $display("FAIL rstmid_next_rx got=%h exp=%h", rx_data, mosi); end
        checks++; if (urun_cnt !== m_urun) begin errors++; $display("FAIL rstmid_underrun got=%0d exp=%0d", urun_cnt, m_urun); end
    endtask

    initial begin
        test_reset();
        test_basic(8'hA5, 8'h3C, 1'b1);
        test_back_to_back(8'h55, 8'hAA, 8'h01, 8'h80);
        test_basic(8'h00, 8'hFF, 1'b0);
        test_abort(8'hC3, 8'(($urandom % 255) + 1), 8'h7E);
        test_no_overwrite(8'h11, 8'h22, 8'(($urandom)));
        test_reset_midframe(8'(($urandom)), 8'(($urandom)), 8'h96);
        for (int k = 0; k < 6; k++) begin
            test_basic(8'(($urandom)), 8'(($urandom)), ($urandom_range(3, 0) != 0));
        end
        test_back_to_back(8'(($urandom)), 8'(($urandom)), 8'(($urandom)), 8'(($urandom)));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
